// File: rtl/hilo_pkg.sv
// Shared HI/LO definitions: write modes, mask bit positions and the pending-entry layout.
package hilo_pkg;

    localparam int HILO_DATA_W = 32;

    typedef enum logic [1:0] {
        HILO_WRITE   = 2'b00,
        HILO_ACC_ADD = 2'b01,
        HILO_ACC_SUB = 2'b10,
        HILO_RSVD    = 2'b11
    } hilo_mode_e;

    localparam int HILO_MASK_HI = 1;
    localparam int HILO_MASK_LO = 0;

    typedef struct packed {
        logic [HILO_DATA_W-1:0] hi;
        logic [HILO_DATA_W-1:0] lo;
        logic [1:0]             mask;
    } hilo_ent_t;

endpackage

// File: rtl/hilo_pend_queue.sv
// In-order circular queue of pending HI/LO writes with per-half youngest-match forwarding.
// Push/pop visible one cycle after the edge; caller gates push with !full; clr beats push.
module hilo_pend_queue
    import hilo_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  hilo_ent_t              push_ent,
    input  logic                   pop,
    input  logic                   clr,
    output hilo_ent_t              head_ent,
    output logic [CW-1:0]          cnt,
    output logic                   full,
    output logic                   fwd_hi_vld,
    output logic [HILO_DATA_W-1:0] fwd_hi,
    output logic                   fwd_lo_vld,
    output logic [HILO_DATA_W-1:0] fwd_lo
);

    hilo_ent_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    assign cnt      = cnt_q;
    assign full     = (cnt_q == CW'(DEPTH));
    assign head_ent = mem_q[head_q];

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        if (clr) begin
            head_d = '0;
            tail_d = '0;
            cnt_d  = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + CW'(1);
                2'b01:   cnt_d = cnt_q - CW'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: only slots inside [head, head+cnt) are ever read.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[tail_q] <= push_ent;
    end

    // Walk oldest to youngest so the last match per half wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx        = '0;
        fwd_hi_vld = 1'b0;
        fwd_lo_vld = 1'b0;
        fwd_hi     = '0;
        fwd_lo     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < cnt_q) begin
                if (mem_q[idx].mask[HILO_MASK_HI]) begin
                    fwd_hi_vld = 1'b1;
                    fwd_hi     = mem_q[idx].hi;
                end
                if (mem_q[idx].mask[HILO_MASK_LO]) begin
                    fwd_lo_vld = 1'b1;
                    fwd_lo     = mem_q[idx].lo;
                end
            end
        end
    end

endmodule

// File: rtl/hilo_spec_reg.sv
// Speculative HI/LO: arch regs + pending queue; enqueue/commit visible next cycle, enq_ready = !full.
// Optional MADD/MSUB datapath (2*DATA_W add/sub on the forwarded view) enabled by `define HILO_ACC_EN.
module hilo_spec_reg
    import hilo_pkg::*;
#(
    parameter int DATA_W = HILO_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [1:0]               enq_mode,
    input  logic [1:0]               enq_mask,
    input  logic [DATA_W-1:0]        enq_hi,
    input  logic [DATA_W-1:0]        enq_lo,
    input  logic                     commit,
    input  logic                     flush,
    output logic [DATA_W-1:0]        rd_hi,
    output logic [DATA_W-1:0]        rd_lo,
    output logic [DATA_W-1:0]        arch_hi,
    output logic [DATA_W-1:0]        arch_lo,
    output logic [$clog2(DEPTH):0]   pend_cnt,
    output logic                     commit_err
);

    logic [DATA_W-1:0] arch_hi_q, arch_hi_d;
    logic [DATA_W-1:0] arch_lo_q, arch_lo_d;
    logic              commit_err_q, commit_err_d;

    logic              full, accept, pop, q_empty;
    hilo_ent_t         push_ent, head_ent;
    logic              fwd_hi_vld, fwd_lo_vld;
    logic [DATA_W-1:0] fwd_hi, fwd_lo;

    hilo_pend_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .push       (accept),
        .push_ent   (push_ent),
        .pop        (pop),
        .clr        (flush),
        .head_ent   (head_ent),
        .cnt        (pend_cnt),
        .full       (full),
        .fwd_hi_vld (fwd_hi_vld),
        .fwd_hi     (fwd_hi),
        .fwd_lo_vld (fwd_lo_vld),
        .fwd_lo     (fwd_lo)
    );

    assign q_empty   = (pend_cnt == '0);
    assign enq_ready = !full;
    assign accept    = enq_valid && enq_ready && !flush;
    assign pop       = commit && !q_empty;

    assign rd_hi = fwd_hi_vld ? fwd_hi : arch_hi_q;
    assign rd_lo = fwd_lo_vld ? fwd_lo : arch_lo_q;

`ifdef HILO_ACC_EN
    hilo_mode_e          mode;
    logic [2*DATA_W-1:0] acc_base, acc_opnd, acc_res;

    assign mode     = hilo_mode_e'(enq_mode);
    assign acc_base = {rd_hi, rd_lo};
    assign acc_opnd = {enq_hi, enq_lo};
    assign acc_res  = (mode == HILO_ACC_SUB) ? (acc_base - acc_opnd) : (acc_base + acc_opnd);

    always_comb begin
        push_ent      = '0;
        push_ent.hi   = enq_hi;
        push_ent.lo   = enq_lo;
        push_ent.mask = enq_mask;
        if (mode == HILO_ACC_ADD || mode == HILO_ACC_SUB) begin
            push_ent.hi   = acc_res[2*DATA_W-1:DATA_W];
            push_ent.lo   = acc_res[DATA_W-1:0];
            push_ent.mask = 2'b11;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = ^enq_mode;

    always_comb begin
        push_ent      = '0;
        push_ent.hi   = enq_hi;
        push_ent.lo   = enq_lo;
        push_ent.mask = enq_mask;
    end
`endif

    // Head retires before a same-cycle flush discards the rest.
    always_comb begin
        arch_hi_d    = arch_hi_q;
        arch_lo_d    = arch_lo_q;
        commit_err_d = commit && q_empty;
        if (pop) begin
            if (head_ent.mask[HILO_MASK_HI]) arch_hi_d = head_ent.hi;
            if (head_ent.mask[HILO_MASK_LO]) arch_lo_d = head_ent.lo;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            arch_hi_q    <= '0;
            arch_lo_q    <= '0;
            commit_err_q <= 1'b0;
        end else begin
            arch_hi_q    <= arch_hi_d;
            arch_lo_q    <= arch_lo_d;
            commit_err_q <= commit_err_d;
        end
    end

    assign arch_hi    = arch_hi_q;
    assign arch_lo    = arch_lo_q;
    assign commit_err = commit_err_q;

endmodule

// File: tb/tb_hilo_spec_reg.sv
// Directed and random stimulus for hilo_spec_reg, checked against a queue-based model of pending writes.
module tb_hilo_spec_reg;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          resetn;
    logic          enq_valid;
    logic          enq_ready;
    logic [1:0]    enq_mode;
    logic [1:0]    enq_mask;
    logic [DW-1:0] enq_hi, enq_lo;
    logic          commit, flush;
    logic [DW-1:0] rd_hi, rd_lo, arch_hi, arch_lo;
    logic [2:0]    pend_cnt;
    logic          commit_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [1:0]    mask;
    } ment_t;

    ment_t         mq[$];
    logic [DW-1:0] m_arch_hi, m_arch_lo;
    logic          m_err;

    always #5 clk = ~clk;

    hilo_spec_reg #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .enq_valid  (enq_valid),
        .enq_ready  (enq_ready),
        .enq_mode   (enq_mode),
        .enq_mask   (enq_mask),
        .enq_hi     (enq_hi),
        .enq_lo     (enq_lo),
        .commit     (commit),
        .flush      (flush),
        .rd_hi      (rd_hi),
        .rd_lo      (rd_lo),
        .arch_hi    (arch_hi),
        .arch_lo    (arch_lo),
        .pend_cnt   (pend_cnt),
        .commit_err (commit_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Forwarded view: youngest pending entry per half, else architectural value.
    function automatic logic [63:0] model_rd();
        logic [DW-1:0] h, l;
        h = m_arch_hi;
        l = m_arch_lo;
        foreach (mq[i]) begin
            if (mq[i].mask[1]) h = mq[i].hi;
            if (mq[i].mask[0]) l = mq[i].lo;
        end
        return {h, l};
    endfunction

    task automatic chk_all(input string tag);
        logic [63:0] r;
        r = model_rd();
        chk({tag, ".rd_hi"},   rd_hi,      r[63:32]);
        chk({tag, ".rd_lo"},   rd_lo,      r[31:0]);
        chk({tag, ".arch_hi"}, arch_hi,    m_arch_hi);
        chk({tag, ".arch_lo"}, arch_lo,    m_arch_lo);
        chk({tag, ".pend"},    pend_cnt,   mq.size());
        chk({tag, ".err"},     commit_err, m_err);
    endtask

    task automatic model_clear();
        mq.delete();
        m_arch_hi = '0;
        m_arch_lo = '0;
        m_err     = 1'b0;
    endtask

    // One clock: drive inputs, check enq_ready against model occupancy, then advance model and compare.
    task automatic cyc(input logic v, input logic [1:0] md, input logic [1:0] mk,
                       input logic [DW-1:0] h, input logic [DW-1:0] l,
                       input logic cm, input logic fl);
        logic [63:0] r, sum;
        ment_t       e, head;
        logic        ok;
        enq_valid = v;
        enq_mode  = md;
        enq_mask  = mk;
        enq_hi    = h;
        enq_lo    = l;
        commit    = cm;
        flush     = fl;
        #1;
        chk("enq_ready", enq_ready, mq.size() != DEPTH);
        r = model_rd();
        sum = 64'(0);
        e.hi = h;
        e.lo = l;
        e.mask = mk;
`ifdef HILO_ACC_EN
        if (md == 2'b01 || md == 2'b10) begin
            sum = (md == 2'b01) ? r + {h, l} : r - {h, l};
            e.hi = sum[63:32];
            e.lo = sum[31:0];
            e.mask = 2'b11;
        end
`endif
        ok = v && (mq.size() != DEPTH) && !fl;
        @(posedge clk);
        #1;
        m_err = cm && (mq.size() == 0);
        if (cm && mq.size() > 0) begin
            head = mq.pop_front();
            if (head.mask[1]) m_arch_hi = head.hi;
            if (head.mask[0]) m_arch_lo = head.lo;
        end
        if (fl) mq.delete();
        else if (ok) mq.push_back(e);
        enq_valid = 1'b0;
        commit    = 1'b0;
        flush     = 1'b0;
        chk_all("cyc");
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        model_clear();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] d;
        resetn    = 1'b0;
        enq_valid = 1'b0;
        enq_mode  = 2'b00;
        enq_mask  = 2'b00;
        enq_hi    = '0;
        enq_lo    = '0;
        commit    = 1'b0;
        flush     = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.rd_hi", rd_hi, 0);
        chk("rst.rd_lo", rd_lo, 0);
        chk("rst.arch_hi", arch_hi, 0);
        chk("rst.pend", pend_cnt, 0);
        chk("rst.ready", enq_ready, 1);
        chk("rst.err", commit_err, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Full write, visible next cycle, then commit.
        cyc(1, 2'b00, 2'b11, 32'h1111_1111, 32'h2222_2222, 0, 0);
        chk("t1.rd_hi", rd_hi, 32'h1111_1111);
        chk("t1.rd_lo", rd_lo, 32'h2222_2222);
        chk("t1.arch_hi", arch_hi, 0);
        cyc(0, 2'b00, 2'b00, 0, 0, 1, 0);
        chk("t1c.arch_lo", arch_lo, 32'h2222_2222);
        chk("t1c.pend", pend_cnt, 0);

        // Partial masks merge per half.
        do_reset();
        cyc(1, 2'b00, 2'b10, 32'hA, 32'h5555, 0, 0);
        cyc(1, 2'b00, 2'b01, 32'h6666, 32'hB, 0, 0);
        chk("t2.rd_hi", rd_hi, 32'hA);
        chk("t2.rd_lo", rd_lo, 32'hB);
        cyc(0, 2'b00, 2'b00, 0, 0, 1, 0);
        chk("t2c.arch_hi", arch_hi, 32'hA);
        chk("t2c.arch_lo", arch_lo, 32'h0);
        cyc(0, 2'b00, 2'b00, 0, 0, 0, 1);

        // Fill, refuse a fifth, commit+offer while full, then flush+commit.
        for (int i = 0; i < DEPTH; i++)
            cyc(1, 2'b00, 2'b11, 32'h100 + i, 32'h200 + i, 0, 0);
        chk("t3.ready", enq_ready, 0);
        cyc(1, 2'b00, 2'b11, 32'hDEAD, 32'hBEEF, 0, 0);
        chk("t3.pend4", pend_cnt, 4);
        cyc(1, 2'b00, 2'b11, 32'hDEAD, 32'hBEEF, 1, 0);
        chk("t3.pend3", pend_cnt, 3);
        chk("t3.arch_hi", arch_hi, 32'h100);
        cyc(0, 2'b00, 2'b00, 0, 0, 1, 1);
        chk("t4.arch_hi", arch_hi, 32'h101);
        chk("t4.pend", pend_cnt, 0);
        chk("t4.rd_eq", rd_lo, arch_lo);
        cyc(0, 2'b00, 2'b00, 0, 0, 1, 0);
        chk("t4.err1", commit_err, 1);
        cyc(0, 2'b00, 2'b00, 0, 0, 0, 0);
        chk("t4.err0", commit_err, 0);

        // Accumulate chain through the forwarded view.
        cyc(1, 2'b00, 2'b11, 32'h0, 32'hFFFF_FFFF, 0, 0);
        cyc(0, 2'b00, 2'b00, 0, 0, 1, 0);
        cyc(1, 2'b01, 2'b11, 32'h0, 32'h1, 0, 0);
`ifdef HILO_ACC_EN
        chk("t5.add_hi", rd_hi, 32'h1);
        chk("t5.add_lo", rd_lo, 32'h0);
`else
        chk("t5.wr_lo", rd_lo, 32'h1);
`endif
        cyc(1, 2'b10, 2'b11, 32'h0, 32'h2, 0, 0);
`ifdef HILO_ACC_EN
        chk("t5.sub_hi", rd_hi, 32'h0);
        chk("t5.sub_lo", rd_lo, 32'hFFFF_FFFE);
`else
        chk("t5.wr_hi", rd_hi, 32'h0);
        chk("t5.wr_lo2", rd_lo, 32'h2);
`endif

        // Asynchronous reset mid-cycle with two pending entries.
        chk("t6.pend2", pend_cnt, 2);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6.rd_hi", rd_hi, 0);
        chk("t6.rd_lo", rd_lo, 0);
        chk("t6.arch_lo", arch_lo, 0);
        chk("t6.pend", pend_cnt, 0);
        chk("t6.ready", enq_ready, 1);
        chk("t6.err", commit_err, 0);
        model_clear();
        @(negedge clk);
        resetn = 1'b1;

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            d = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : DW'($urandom);
            cyc($urandom_range(0, 9) < 6,
                2'($urandom_range(0, 3)),
                2'($urandom_range(0, 3)),
                d,
                DW'($urandom),
                $urandom_range(0, 19) < 7,
                $urandom_range(0, 19) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
